// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader is the slave side; the host link / observer is the master side.
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              err;

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream program loader: reassembles 16-bit words from a byte link
// and writes them sequentially into the instruction memory, holding the CPU meanwhile.
module imem_loader #(
  parameter int         ADDR_W    = 10,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic          clk,
  input logic          rst_n,
  imem_loader_if.slave bus
);

  localparam int                HI_W = ADDR_W - 8;
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [3:0] {
    IDLE,
    AHI,
    ALO,
    CHI,
    CLO,
    DHI,
    DLO,
    WRITE,
    CHK
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              ready_c;
  logic              accept;
  logic [HI_W-1:0]   addr_hi;
  logic [7:0]        addr_lo;
  logic [HI_W-1:0]   cnt_hi;
  logic [ADDR_W-1:0] hdr_cnt;
  logic [ADDR_W-1:0] remaining;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [15:0]       wdata_q;
  logic [7:0]        hi_byte;
  logic [7:0]        checksum;
  logic              we_q;
  logic              hold_q;
  logic              done_q;
  logic              err_q;

  assign accept  = bus.rx_valid && ready_c;
  assign hdr_cnt = {cnt_hi, bus.rx_data};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Every state except WRITE waits for an accepted byte; WRITE always lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && (bus.rx_data == SYNC_BYTE)) state_nxt = AHI;
      AHI:     if (accept) state_nxt = ALO;
      ALO:     if (accept) state_nxt = CHI;
      CHI:     if (accept) state_nxt = CLO;
      CLO:     if (accept) state_nxt = (hdr_cnt == '0) ? CHK : DHI;
      DHI:     if (accept) state_nxt = DLO;
      DLO:     if (accept) state_nxt = WRITE;
      WRITE:   state_nxt = (remaining == ONE) ? CHK : DHI;
      CHK:     if (accept) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready_c = (state != WRITE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_hi <= '0;
      addr_lo <= '0;
      cnt_hi  <= '0;
    end else if (accept) begin
      case (state)
        AHI:     addr_hi <= bus.rx_data[HI_W-1:0];
        ALO:     addr_lo <= bus.rx_data;
        CHI:     cnt_hi  <= bus.rx_data[HI_W-1:0];
        default: ;
      endcase
    end
  end

  // remaining counts the words still to be written, including the one in WRITE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q <= '0;
      remaining  <= '0;
    end else if (state == WRITE) begin
      mem_addr_q <= mem_addr_q + ONE;
      remaining  <= remaining - ONE;
    end else if (accept && (state == CLO)) begin
      mem_addr_q <= {addr_hi, addr_lo};
      remaining  <= hdr_cnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_byte  <= '0;
      wdata_q  <= '0;
      checksum <= '0;
    end else if (accept) begin
      case (state)
        IDLE: if (bus.rx_data == SYNC_BYTE) checksum <= '0;
        DHI: begin
          hi_byte  <= bus.rx_data;
          checksum <= checksum ^ bus.rx_data;
        end
        DLO: begin
          wdata_q  <= {hi_byte, bus.rx_data};
          checksum <= checksum ^ bus.rx_data;
        end
        default: ;
      endcase
    end
  end

  // Status flags are registered so that done/err line up with cpu_hold dropping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q   <= 1'b0;
      hold_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= (state_nxt == WRITE);
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (accept && (state == IDLE) && (bus.rx_data == SYNC_BYTE)) begin
        hold_q <= 1'b1;
      end else if (accept && (state == CHK)) begin
        hold_q <= 1'b0;
        done_q <= (bus.rx_data == checksum);
        err_q  <= (bus.rx_data != checksum);
      end
    end
  end

  assign bus.rx_ready  = ready_c;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.cpu_hold  = hold_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames plus randomized frames,
// checked every cycle against a frame-level reference model of the byte protocol.
module tb_imem_loader;

  logic clk = 1'b0;
  logic rst_n;

  imem_loader_if #(.ADDR_W(10)) bus ();

  imem_loader #(.ADDR_W(10), .SYNC_BYTE(8'hA5)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Frame-level model state and the expectations for the coming cycle
  bit         m_in      = 1'b0;
  int         m_k       = 0;
  int         m_addr    = 0;
  int         m_n       = 0;
  logic [7:0] m_xor     = 8'h00;
  logic [7:0] m_hi      = 8'h00;
  logic       exp_ready = 1'b1;
  logic       exp_we    = 1'b0;
  logic       exp_done  = 1'b0;
  logic       exp_err   = 1'b0;
  logic       exp_hold  = 1'b0;
  logic [9:0] exp_addr  = 10'h000;
  logic [15:0] exp_wdata = 16'h0000;

  logic [15:0] obs_mem [1024];
  int obs_writes = 0;
  int obs_done   = 0;
  int obs_err    = 0;

  logic [7:0] tx_q [$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Byte k of a frame after SYNC: 0..3 header, then 2n data bytes, then the checksum.
  task automatic model_byte(input logic [7:0] b);
    int idx;
    if (!m_in) begin
      if (b == 8'hA5) begin
        m_in     = 1'b1;
        m_k      = 0;
        m_xor    = 8'h00;
        exp_hold = 1'b1;
      end
    end else begin
      idx = m_k - 4;
      if (m_k == 0)      m_addr = int'(b[1:0]) * 256;
      else if (m_k == 1) m_addr = m_addr + int'(b);
      else if (m_k == 2) m_n    = int'(b[1:0]) * 256;
      else if (m_k == 3) m_n    = m_n + int'(b);
      else if (idx < 2 * m_n) begin
        m_xor = m_xor ^ b;
        if (idx % 2 == 0) begin
          m_hi = b;
        end else begin
          exp_we    = 1'b1;
          exp_addr  = 10'((m_addr + idx / 2) % 1024);
          exp_wdata = {m_hi, b};
        end
      end else begin
        if (b == m_xor) exp_done = 1'b1;
        else            exp_err  = 1'b1;
        m_in     = 1'b0;
        exp_hold = 1'b0;
      end
      m_k++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      m_in      = 1'b0;
      exp_ready = 1'b1;
      exp_we    = 1'b0;
      exp_done  = 1'b0;
      exp_err   = 1'b0;
      exp_hold  = 1'b0;
      checkOutput("rst_rx_ready",  bus.rx_ready,  32'd1);
      checkOutput("rst_mem_we",    bus.mem_we,    32'd0);
      checkOutput("rst_mem_addr",  bus.mem_addr,  32'd0);
      checkOutput("rst_mem_wdata", bus.mem_wdata, 32'd0);
      checkOutput("rst_cpu_hold",  bus.cpu_hold,  32'd0);
      checkOutput("rst_done",      bus.done,      32'd0);
      checkOutput("rst_err",       bus.err,       32'd0);
    end else begin
      checkOutput("rx_ready", bus.rx_ready, exp_ready);
      checkOutput("mem_we",   bus.mem_we,   exp_we);
      if (exp_we) begin
        checkOutput("mem_addr",  bus.mem_addr,  exp_addr);
        checkOutput("mem_wdata", bus.mem_wdata, exp_wdata);
      end
      checkOutput("done",          bus.done,            exp_done);
      checkOutput("err",           bus.err,             exp_err);
      checkOutput("cpu_hold",      bus.cpu_hold,        exp_hold);
      checkOutput("done_err_excl", bus.done & bus.err,  32'd0);
      if (bus.mem_we === 1'b1 && !$isunknown(bus.mem_addr)) begin
        obs_mem[bus.mem_addr] = bus.mem_wdata;
        obs_writes++;
      end
      if (bus.done === 1'b1) obs_done++;
      if (bus.err === 1'b1)  obs_err++;
      exp_we   = 1'b0;
      exp_done = 1'b0;
      exp_err  = 1'b0;
      if (bus.rx_valid && exp_ready) model_byte(bus.rx_data);
      exp_ready = !exp_we;
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int gap);
    int waited;
    waited       = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.rx_ready === 1'b1) break;
      waited++;
      if (waited > 64) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL accept_timeout: byte 0x%0h waited %0d cycles, expected acceptance", b, waited);
        break;
      end
    end
    @(posedge clk);
    #1;
    if (gap > 0) begin
      bus.rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic flushTx(input int maxgap);
    while (tx_q.size() > 0) begin
      applyStimulus(tx_q.pop_front(), (maxgap == 0) ? 0 : int'($urandom_range(0, maxgap)));
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0, e0, w0, n, gmax;
    logic [9:0] av;
    logic [7:0] x, b;

    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    rst_n        = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two words at 0x010; checksum 12^34^AB^CD = 40
    d0 = obs_done; e0 = obs_err; w0 = obs_writes;
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    flushTx(2);
    settle();
    checkOutput("t1_mem010", obs_mem[16], 32'h1234);
    checkOutput("t1_mem011", obs_mem[17], 32'hABCD);
    checkOutput("t1_done",   obs_done - d0, 32'd1);
    checkOutput("t1_err",    obs_err - e0,  32'd0);
    checkOutput("t1_hold",   bus.cpu_hold,  32'd0);

    // Bad checksum: writes still happen, err instead of done
    d0 = obs_done; e0 = obs_err; w0 = obs_writes;
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h81};
    flushTx(1);
    settle();
    checkOutput("t2_writes", obs_writes - w0, 32'd2);
    checkOutput("t2_err",    obs_err - e0,    32'd1);
    checkOutput("t2_done",   obs_done - d0,   32'd0);

    // Garbage before SYNC, empty frame
    d0 = obs_done; w0 = obs_writes;
    tx_q = '{8'h00, 8'hFF, 8'h3C, 8'hA5, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00};
    flushTx(1);
    settle();
    checkOutput("t3_writes", obs_writes - w0, 32'd0);
    checkOutput("t3_done",   obs_done - d0,   32'd1);

    // Address wrap 0x3FF -> 0x000
    d0 = obs_done;
    tx_q = '{8'hA5, 8'h03, 8'hFF, 8'h00, 8'h02, 8'h11, 8'h11, 8'h22, 8'h22, 8'h00};
    flushTx(2);
    settle();
    checkOutput("t4_mem3ff", obs_mem[1023], 32'h1111);
    checkOutput("t4_mem000", obs_mem[0],    32'h2222);
    checkOutput("t4_done",   obs_done - d0, 32'd1);

    // rx_valid held high throughout; SYNC values inside data are ordinary data
    d0 = obs_done; w0 = obs_writes;
    tx_q = '{8'hA5, 8'hFE, 8'h00, 8'hFC, 8'h04, 8'hA5, 8'hA5, 8'h01, 8'h02,
             8'hA5, 8'h00, 8'h3C, 8'h4D, 8'hD7};
    flushTx(0);
    settle();
    checkOutput("t5_mem200", obs_mem[512], 32'hA5A5);
    checkOutput("t5_mem203", obs_mem[515], 32'h3C4D);
    checkOutput("t5_writes", obs_writes - w0, 32'd4);
    checkOutput("t5_done",   obs_done - d0,   32'd1);

    // Reset mid-frame after the first word was written, then a clean frame
    d0 = obs_done; e0 = obs_err; w0 = obs_writes;
    tx_q = '{8'hA5, 8'h00, 8'h10, 8'h00, 8'h02, 8'h12, 8'h34};
    flushTx(1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("t6_partial", obs_writes - w0, 32'd1);
    checkOutput("t6_nopulse", (obs_done - d0) + (obs_err - e0), 32'd0);
    d0 = obs_done;
    tx_q = '{8'hA5, 8'h00, 8'h55, 8'h00, 8'h01, 8'hBE, 8'hEF, 8'h51};
    flushTx(1);
    settle();
    checkOutput("t6_mem055", obs_mem[85],   32'hBEEF);
    checkOutput("t6_done",   obs_done - d0, 32'd1);

    // Randomized frames: each yields exactly one done or err pulse
    d0 = obs_done; e0 = obs_err;
    for (int f = 0; f < 40; f++) begin
      n    = int'($urandom_range(0, 6));
      av   = (f % 5 == 0) ? 10'(1024 - int'($urandom_range(1, 3))) : 10'($urandom_range(0, 1023));
      gmax = int'($urandom_range(0, 3));
      x    = 8'h00;
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h5A;
        tx_q.push_back(b);
      end
      tx_q.push_back(8'hA5);
      tx_q.push_back({6'($urandom), av[9:8]});
      tx_q.push_back(av[7:0]);
      tx_q.push_back({6'($urandom), 2'b00});
      tx_q.push_back(8'(n));
      for (int i = 0; i < 2 * n; i++) begin
        b = (($urandom_range(0, 7)) == 0) ? 8'hA5 : 8'($urandom);
        x = x ^ b;
        tx_q.push_back(b);
      end
      if ($urandom_range(0, 3) == 0) tx_q.push_back(x ^ 8'($urandom_range(1, 255)));
      else                           tx_q.push_back(x);
      flushTx(gmax);
      settle();
    end
    checkOutput("rand_frames", (obs_done - d0) + (obs_err - e0), 32'd40);

    settle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
